// File: rtl/mux2_arb_pkg.sv
// Shared types and select encoding for the two-stream round-robin mux arbiter.
package mux2_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOCK_A = 2'd1,
    LOCK_B = 2'd2
  } state_e;

  // Select polarity matches the MUX2S1 cells: 0 picks input a, 1 picks input b.
  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

endpackage

// File: rtl/mux2_rr_pick.sv
// Combinational 2-way round-robin picker; ptr breaks the tie when both request.
module mux2_rr_pick
  import mux2_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       ptr,
  output logic       gnt_sel,
  output logic       gnt_vld
);

  always_comb begin
    gnt_vld = |req;
    gnt_sel = ptr;
    if (req == 2'b01)      gnt_sel = SEL_A;
    else if (req == 2'b10) gnt_sel = SEL_B;
  end

endmodule

// File: rtl/mux2_rr_arb.sv
// Round-robin arbiter sharing one registered 2:1 mux between two valid/ready streams.
// state  | meaning
// IDLE   | no packet owns the mux; round-robin pick every beat
// LOCK_A | A is mid-packet; only A is served until its last beat
// LOCK_B | B is mid-packet; only B is served until its last beat
module mux2_rr_arb
  import mux2_arb_pkg::*;
#(
  parameter int DW       = 8,
  parameter bit LOCK_PKT = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          a_valid,
  input  logic [DW-1:0] a_data,
  input  logic          a_last,
  output logic          a_ready,
  input  logic          b_valid,
  input  logic [DW-1:0] b_data,
  input  logic          b_last,
  output logic          b_ready,
  output logic          y_valid,
  output logic [DW-1:0] y_data,
  output logic          y_last,
  input  logic          y_ready,
  output logic          s0
);

  state_e          state_q, state_d;
  logic            ptr_q, ptr_d;
  logic            y_valid_q;
  logic [DW-1:0]   y_data_q;
  logic            y_last_q;
  logic            s0_q;

  logic            pick_sel, pick_vld;
  logic            sel, sel_vld;
  logic            slot_free;
  logic            a_fire, b_fire, fire, fire_last;

  mux2_rr_pick u_pick (
    .req     ({b_valid, a_valid}),
    .ptr     (ptr_q),
    .gnt_sel (pick_sel),
    .gnt_vld (pick_vld)
  );

  assign slot_free = !y_valid_q || y_ready;

  // A locked owner keeps the grant even while its valid is low.
  always_comb begin
    sel     = pick_sel;
    sel_vld = pick_vld;
    case (state_q)
      LOCK_A: begin sel = SEL_A; sel_vld = 1'b1; end
      LOCK_B: begin sel = SEL_B; sel_vld = 1'b1; end
      default: ;
    endcase
  end

  assign a_ready   = slot_free && sel_vld && (sel == SEL_A);
  assign b_ready   = slot_free && sel_vld && (sel == SEL_B);
  assign a_fire    = a_valid && a_ready;
  assign b_fire    = b_valid && b_ready;
  assign fire      = a_fire || b_fire;
  assign fire_last = a_fire ? a_last : b_last;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    if (fire) begin
      if (!LOCK_PKT) begin
        ptr_d = ~sel;
      end else if (fire_last) begin
        state_d = IDLE;
        ptr_d   = ~sel;
      end else begin
        state_d = (sel == SEL_A) ? LOCK_A : LOCK_B;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= SEL_A;
      y_valid_q <= 1'b0;
      y_data_q  <= '0;
      y_last_q  <= 1'b0;
      s0_q      <= SEL_A;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      if (fire) begin
        y_valid_q <= 1'b1;
        y_data_q  <= a_fire ? a_data : b_data;
        y_last_q  <= fire_last;
        s0_q      <= sel;
      end else if (slot_free) begin
        y_valid_q <= 1'b0;
      end
    end
  end

  assign y_valid = y_valid_q;
  assign y_data  = y_data_q;
  assign y_last  = y_last_q;
  assign s0      = s0_q;

endmodule

// File: tb/tb_mux2_rr_arb.sv
// Bench for mux2_rr_arb: one locking and one non-locking instance against a packet-level model.
module tb_mux2_rr_arb;

  logic       clk;
  logic       rst [2];
  logic       av [2], al [2], ar [2];
  logic       bv [2], bl [2], br [2];
  logic [7:0] ad [2], bd [2];
  logic       yv [2], yl [2], yr [2], s0o [2];
  logic [7:0] yd [2];

  int n_tests = 0;
  int n_fail  = 0;

  // Model: lock owner (-1 none, 0 A, 1 B), priority source, and the output register.
  int         lockp [2] = '{1, 0};
  int         own [2];
  int         ptr [2];
  bit         m_yv [2];
  logic [7:0] m_yd [2];
  bit         m_yl [2];
  int         m_s0 [2];
  int         last_w [2];

  mux2_rr_arb #(.DW(8), .LOCK_PKT(1'b1)) u_lk (
    .clk(clk), .rst(rst[0]),
    .a_valid(av[0]), .a_data(ad[0]), .a_last(al[0]), .a_ready(ar[0]),
    .b_valid(bv[0]), .b_data(bd[0]), .b_last(bl[0]), .b_ready(br[0]),
    .y_valid(yv[0]), .y_data(yd[0]), .y_last(yl[0]), .y_ready(yr[0]),
    .s0(s0o[0])
  );

  mux2_rr_arb #(.DW(8), .LOCK_PKT(1'b0)) u_nl (
    .clk(clk), .rst(rst[1]),
    .a_valid(av[1]), .a_data(ad[1]), .a_last(al[1]), .a_ready(ar[1]),
    .b_valid(bv[1]), .b_data(bd[1]), .b_last(bl[1]), .b_ready(br[1]),
    .y_valid(yv[1]), .y_data(yd[1]), .y_last(yl[1]), .y_ready(yr[1]),
    .s0(s0o[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  function automatic int pick_w(int d);
    if (m_yv[d] && !yr[d]) return -1;
    if (lockp[d] != 0 && own[d] == 0) return av[d] ? 0 : -1;
    if (lockp[d] != 0 && own[d] == 1) return bv[d] ? 1 : -1;
    if (av[d] && bv[d]) return ptr[d];
    if (av[d]) return 0;
    if (bv[d]) return 1;
    return -1;
  endfunction

  // Called at a falling edge with inputs already applied; returns at the next falling edge.
  task automatic cycle();
    int         w [2];
    logic [7:0] wd [2];
    bit         wl [2];
    bit         fr [2];
    #1;
    for (int d = 0; d < 2; d++) begin
      w[d]  = pick_w(d);
      wd[d] = (w[d] == 1) ? bd[d] : ad[d];
      wl[d] = (w[d] == 1) ? bl[d] : al[d];
      fr[d] = !m_yv[d] || yr[d];
      chk($sformatf("a_accept[%0d]", d), av[d] && ar[d], w[d] == 0);
      chk($sformatf("b_accept[%0d]", d), bv[d] && br[d], w[d] == 1);
      chk($sformatf("rdy_excl[%0d]", d), ar[d] && br[d], 0);
      if (!fr[d]) chk($sformatf("bp_rdy[%0d]", d), ar[d] || br[d], 0);
    end
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      if (rst[d]) begin
        own[d] = -1; ptr[d] = 0; m_yv[d] = 0; m_yd[d] = 8'h00; m_yl[d] = 0; m_s0[d] = 0;
      end else if (w[d] >= 0) begin
        m_yv[d] = 1; m_yd[d] = wd[d]; m_yl[d] = wl[d]; m_s0[d] = w[d];
        if (lockp[d] == 0) ptr[d] = 1 - w[d];
        else if (wl[d]) begin own[d] = -1; ptr[d] = 1 - w[d]; end
        else own[d] = w[d];
      end else if (fr[d]) begin
        m_yv[d] = 0;
      end
      last_w[d] = w[d];
      chk($sformatf("y_valid[%0d]", d), yv[d], m_yv[d]);
      chk($sformatf("y_data[%0d]", d), yd[d], m_yd[d]);
      chk($sformatf("y_last[%0d]", d), yl[d], m_yl[d]);
      chk($sformatf("s0[%0d]", d), s0o[d], m_s0[d]);
    end
    @(negedge clk);
  endtask

  task automatic idle_in(input int d);
    av[d] = 0; ad[d] = 8'h00; al[d] = 0;
    bv[d] = 0; bd[d] = 8'h00; bl[d] = 0;
    yr[d] = 1;
  endtask

  task automatic do_rst(input int d);
    idle_in(d);
    rst[d] = 1;
    cycle();
    rst[d] = 0;
  endtask

  localparam int LK_N = 6;
  logic       lk_av [LK_N] = '{1, 1, 0, 0, 1, 0};
  logic [7:0] lk_ad [LK_N] = '{8'h01, 8'h02, 8'h00, 8'h00, 8'h03, 8'h00};
  logic       lk_al [LK_N] = '{0, 0, 0, 0, 1, 0};
  logic       lk_br [LK_N] = '{0, 0, 0, 0, 0, 1};

  initial begin
    for (int d = 0; d < 2; d++) begin
      idle_in(d);
      rst[d] = 1;
      own[d] = -1; ptr[d] = 0; m_yv[d] = 0; m_yd[d] = 8'h00; m_yl[d] = 0; m_s0[d] = 0;
      last_w[d] = -1;
    end
    @(negedge clk);
    cycle();
    cycle();
    rst[0] = 0; rst[1] = 0;

    chk("rst_yv", yv[0], 0);
    chk("rst_yd", yd[0], 8'h00);
    chk("rst_s0", s0o[0], 0);

    // First beat: accepted combinationally, visible one cycle later.
    av[0] = 1; ad[0] = 8'h11; al[0] = 1;
    #1 chk("first_a_ready", ar[0], 1);
    cycle();
    chk("first_yv", yv[0], 1);
    chk("first_yd", yd[0], 8'h11);
    chk("first_s0", s0o[0], 0);
    av[0] = 0;

    // Both valid with single-beat packets: strict alternation at full rate.
    do_rst(0);
    av[0] = 1; ad[0] = 8'hAA; al[0] = 1;
    bv[0] = 1; bd[0] = 8'hBB; bl[0] = 1;
    for (int i = 0; i < 6; i++) begin
      cycle();
      chk("alt_s0", s0o[0], i % 2);
      chk("alt_yv", yv[0], 1);
      chk("alt_yd", yd[0], (i % 2) ? 8'hBB : 8'hAA);
    end

    // Packet lock: B is held off through A's gap until A's last beat is taken.
    do_rst(0);
    bv[0] = 1; bd[0] = 8'hB1; bl[0] = 1;
    for (int i = 0; i < LK_N; i++) begin
      av[0] = lk_av[i]; ad[0] = lk_ad[i]; al[0] = lk_al[i];
      #1 chk("lock_b_ready", br[0], lk_br[i]);
      cycle();
    end
    chk("lock_b_yd", yd[0], 8'hB1);
    chk("lock_b_s0", s0o[0], 1);
    bv[0] = 0;

    // Backpressure: output held, no readies, then both waiting beats drain in order.
    do_rst(0);
    av[0] = 1; ad[0] = 8'hA5; al[0] = 1;
    cycle();
    yr[0] = 0;
    ad[0] = 8'h5A;
    bv[0] = 1; bd[0] = 8'hC3; bl[0] = 1;
    for (int i = 0; i < 4; i++) begin
      #1 chk("bp_ready", ar[0] || br[0], 0);
      cycle();
      chk("bp_yd", yd[0], 8'hA5);
      chk("bp_s0", s0o[0], 0);
    end
    yr[0] = 1;
    cycle();
    chk("rel_yd_b", yd[0], 8'hC3);
    chk("rel_s0_b", s0o[0], 1);
    bv[0] = 0;
    cycle();
    chk("rel_yd_a", yd[0], 8'h5A);
    chk("rel_s0_a", s0o[0], 0);
    av[0] = 0;

    // Reset mid-packet drops the lock and the held beat.
    do_rst(0);
    bv[0] = 1; bd[0] = 8'h66; bl[0] = 0; yr[0] = 0;
    cycle();
    chk("mid_yv", yv[0], 1);
    bv[0] = 0; rst[0] = 1;
    cycle();
    rst[0] = 0;
    chk("mid_rst_yv", yv[0], 0);
    av[0] = 1; ad[0] = 8'h77; al[0] = 1;
    bv[0] = 1; bd[0] = 8'h88; bl[0] = 0; yr[0] = 1;
    #1 chk("mid_a_first", ar[0], 1);
    cycle();
    chk("mid_s0", s0o[0], 0);
    idle_in(0);

    // Non-locking instance: multi-beat packets still alternate per beat.
    do_rst(1);
    av[1] = 1; ad[1] = 8'h21; al[1] = 0;
    bv[1] = 1; bd[1] = 8'h42; bl[1] = 0;
    for (int i = 0; i < 6; i++) begin
      cycle();
      chk("nl_alt_s0", s0o[1], i % 2);
    end
    idle_in(1);
    cycle();

    // Randomized traffic on both instances; sources hold a beat until it is taken.
    for (int n = 0; n < 1500; n++) begin
      for (int d = 0; d < 2; d++) begin
        if (last_w[d] == 0) av[d] = 0;
        if (last_w[d] == 1) bv[d] = 0;
        if (!av[d] && $urandom_range(0, 9) < 6) begin
          av[d] = 1; ad[d] = 8'($urandom); al[d] = ($urandom_range(0, 2) == 0);
        end
        if (!bv[d] && $urandom_range(0, 9) < 6) begin
          bv[d] = 1; bd[d] = 8'($urandom); bl[d] = ($urandom_range(0, 2) == 0);
        end
        yr[d]  = ($urandom_range(0, 3) != 0);
        rst[d] = ($urandom_range(0, 299) == 0);
      end
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
